// File: rtl/scb_multi_pip.sv
// Writeback-slot scoreboard for multi-cycle execution pipes.
// Each issued uop reserves the single writeback cycle it will complete in.
module scb_multi_pip #(
    parameter int W_PA_REG   = 5,
    parameter int W_PD_UOPS  = 6,
    parameter int N_PIP      = 4,
    parameter int W_PIP      = 2,
    parameter int S_AMT_CELL = 8,
    parameter int W_LAT      = 7,
    parameter bit P_WAW_CHK  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W_PD_UOPS-1:0]     CDI_PD_uops,
    input  logic [W_PA_REG-1:0]      CDI_PD_rd,
    input  logic [W_PIP-1:0]         CDI_PC_pip,
    input  logic [W_LAT-1:0]         CDI_PD_lat,
    input  logic                     CFI_PC_clear,
    output logic                     CDO_PC_acc,
    output logic                     CDO_PC_wbvld,
    output logic [W_PA_REG-1:0]      CDO_PC_rd,
    output logic [W_PIP-1:0]         CDO_PC_selwb,
    output logic [2**W_PA_REG-1:0]   CDO_PC_busy,
    output logic                     CDO_PC_full
);

    localparam int W_IDX = (S_AMT_CELL > 1) ? $clog2(S_AMT_CELL) : 1;

    logic [S_AMT_CELL-1:0] valid_q;
    logic [W_PIP-1:0]      pip_q [S_AMT_CELL];
    logic [W_PA_REG-1:0]   rd_q  [S_AMT_CELL];
    logic [W_LAT-1:0]      cnt_q [S_AMT_CELL];

    logic              free_found;
    logic [W_IDX-1:0]  free_idx;
    logic              slot_hit;
    logic              done_found;
    logic [W_IDX-1:0]  done_idx;
    logic              req;
    logic              pip_ok;
    logic              waw_hit;

    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        slot_hit    = 1'b0;
        done_found  = 1'b0;
        done_idx    = '0;
        CDO_PC_busy = '0;
        CDO_PC_full = 1'b1;
        for (int i = 0; i < S_AMT_CELL; i++) begin
            if (!valid_q[i]) begin
                CDO_PC_full = 1'b0;
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = W_IDX'(i);
                end
            end else begin
                CDO_PC_busy[rd_q[i]] = 1'b1;
                if (cnt_q[i] == CDI_PD_lat) slot_hit = 1'b1;
                if (cnt_q[i] == '0) begin
                    done_found = 1'b1;
                    done_idx   = W_IDX'(i);
                end
            end
        end
    end

    assign req     = (CDI_PD_uops != '1);
    assign pip_ok  = (32'(CDI_PC_pip) < N_PIP);
    assign waw_hit = P_WAW_CHK && CDO_PC_busy[CDI_PD_rd];

    assign CDO_PC_acc = !rst && req && !CFI_PC_clear && (CDI_PD_lat != '0)
                        && free_found && !slot_hit && !waw_hit && pip_ok;

    // A flush hides the completing uop; it is dropped with the rest.
    assign CDO_PC_wbvld = done_found && !CFI_PC_clear;
    assign CDO_PC_rd    = CDO_PC_wbvld ? rd_q[done_idx]  : '0;
    assign CDO_PC_selwb = CDO_PC_wbvld ? pip_q[done_idx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < S_AMT_CELL; i++) begin
                pip_q[i] <= '0;
                rd_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else if (CFI_PC_clear) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < S_AMT_CELL; i++) begin
                if (valid_q[i]) begin
                    if (cnt_q[i] == '0) valid_q[i] <= 1'b0;
                    else                cnt_q[i]   <= cnt_q[i] - W_LAT'(1);
                end
            end
            if (CDO_PC_acc) begin
                valid_q[free_idx] <= 1'b1;
                pip_q[free_idx]   <= CDI_PC_pip;
                rd_q[free_idx]    <= CDI_PD_rd;
                cnt_q[free_idx]   <= CDI_PD_lat - W_LAT'(1);
            end
        end
    end

endmodule
